pe_vinsn_queue: RTL and testbench
=================================

# pe_vinsn_queue

Receiving end of the sequencer-to-PE request interface. Each processing element (lane front-end, load, store, slide or mask unit) instantiates one to accept the `pe_req_t` stream. It filters requests addressed to its VFU and drops repeats of a request the sequencer holds while other PEs stall. Accepted instructions are buffered in order, their hazard bits are pruned against the broadcast `vinsn_running`, the head is handed to the execution backend, and backend completions are returned as `pe_resp_t.vinsn_done` pulses.

## Interface
- `Vfu`, default `VFU_Alu`: `vfu_e` value this instance accepts.
- `QueueDepth`, default 4: number of buffered, not-yet-issued instructions; power of two, at least 2.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `pe_req_i` in `pe_req_t`: request from the sequencer. The `vinsn_running` field is valid every cycle.
- `pe_req_valid_i` in 1: request valid. Held by the sequencer until all PEs are ready.
- `pe_req_ready_o` out 1: this PE is ready for the request.
- `pe_resp_o` out `pe_resp_t`: response to the sequencer. Only `vinsn_done[NrVInsn-1:0]` is driven; all other fields are 0.
- `exe_req_o` out `pe_req_t`: head instruction, with hazards already pruned.
- `exe_valid_o` out 1: head valid and issuable.
- `exe_ready_i` in 1: backend accepts the head.
- `exe_done_i` in 1: backend finished an instruction.
- `exe_done_id_i` in `vid_t`: ID of the finished instruction.

## Operation
- **Ownership vector `owned_q[NrVInsn]`.**
  - Set on accept; cleared on done.
  - Covers both queued and executing instructions.
- **Accept condition:** `pe_req_valid_i && pe_req_i.vfu == Vfu && !owned_q[pe_req_i.id] && !full`.
  - On accept, push `pe_req_i` at the tail and set `owned_q[id]`.
- **Ready:** `pe_req_ready_o = !full || pe_req_i.vfu != Vfu || owned_q[pe_req_i.id]`.
  - Non-matching requests and already-owned requests never stall the sequencer.
  - `full` is computed from the registered count. A push is refused when full, even if a pop happens in the same cycle.
- **Duplicate suppression:** while the sequencer holds the same request valid across stall cycles, the `owned_q[id]` check prevents a second push.
- **Hazard pruning:** every cycle, each stored entry's `hazard_vs1`, `hazard_vs2`, `hazard_vm` and `hazard_vd` are ANDed with `pe_req_i.vinsn_running`.
  - This happens regardless of `pe_req_valid_i`.
  - On push, the incoming hazards are also ANDed before storing.
- **Issue:** `exe_valid_o = !empty && head.hazard_vd == '0`.
  - WAW must clear before issue.
  - Read hazards are forwarded in `exe_req_o` so the backend can chain on them.
  - `exe_req_o` presents the pruned head combinationally from storage.
  - Pop on `exe_valid_o && exe_ready_i`.
- **Completion:** on `exe_done_i`:
  - Clear `owned_q[exe_done_id_i]`.
  - Drive the one-hot `pe_resp_o.vinsn_done[exe_done_id_i]` for exactly one cycle, registered.
- **Illegal done:** `exe_done_i` for an ID not in `owned_q` is ignored (no pulse) and flagged by an assertion.
- **Simultaneous events:** push, pop and done in the same cycle are all legal.
  - Count is updated as `count + push - pop`.
  - Done and accept target different IDs by construction: the sequencer reuses an ID only after `vinsn_running` drops it, which follows our done pulse.
- **Pointers:** read and write pointers are `$clog2(QueueDepth)` bits and wrap naturally. Count is `$clog2(QueueDepth)+1` bits.

## Timing
- **Reset values:**
  - `pe_req_ready_o` = 1, because the queue is empty.
  - `exe_valid_o` = 0.
  - `exe_req_o` = 0.
  - `pe_resp_o` = 0.
  - `owned_q` = 0; pointers and count = 0.
- **Accept to `exe_valid_o`:** 1 cycle (accept at edge N, head visible in cycle N+1), provided `hazard_vd` is 0.
- **`exe_done_i` to `vinsn_done` pulse:** 1 cycle.
- **Pruning latency:** a hazard bit clears in the cycle after `vinsn_running` drops it, because the stored copy updates at the edge. `exe_valid_o` follows in the same cycle as the cleared bit.
- **Throughput:** one accept and one issue per cycle sustained.
- **Reset mid-operation:** all queued and owned state is discarded. No done pulses are emitted for discarded instructions.

## Test plan
- **Basic flow:** `Vfu=VFU_Alu`, request id 3 with no hazards, `exe_ready_i`=1 → `exe_valid_o` with id 3 in the next cycle. Then `exe_done_i` with id 3 → `vinsn_done` = 0b1000 one cycle later, for exactly one cycle.
- **Filtering and duplicates:**
  - Load-unit request → ready=1, never issued.
  - ALU id 2 held valid for 5 cycles → pushed once; count=1.
- **Full:** `QueueDepth`=4, `exe_ready_i`=0, push ids 0–3.
  - New id 4 → `pe_req_ready_o`=0.
  - Re-presented id 3 → ready=1.
  - Pop one → id 4 accepted.
- **WAW gating:** push id 1 with `hazard_vd`=0b1 while `vinsn_running` bit 0 is set → `exe_valid_o`=0. Drop `vinsn_running` bit 0 → `exe_valid_o`=1 one cycle later, with `exe_req_o.hazard_vd`=0.
- **Simultaneous:** push id 5, pop head, and done for id 2 in the same cycle → count unchanged, `vinsn_done`=0b100, `owned_q[5]`=1.
- **Reset mid-op:** 3 queued instructions, assert `rst_ni` low → all outputs at reset values. No `vinsn_done` pulses after release.

Source files
------------

// File: rtl/pe_vinsn_queue.sv
// pe_vinsn_queue: receiving end of the sequencer-to-PE request interface.
// Accepts requests addressed to this PE's VFU, drops repeats of a request the
// sequencer keeps holding, buffers accepted instructions in order, prunes their
// hazard bits against the broadcast vinsn_running, presents the head to the
// execution backend and returns backend completions as vinsn_done pulses.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   pe_req_i/_valid_i      request stream from the sequencer (vinsn_running valid every cycle)
//   pe_req_ready_o         this PE does not stall the current request
//   pe_resp_o              vinsn_done one-hot pulses, all other fields zero
//   exe_req_o/exe_valid_o  pruned head instruction and its issuability
//   exe_ready_i            backend accepts the head
//   exe_done_i/_id_i       backend completion and its instruction ID

package pe_vinsn_pkg;
    localparam int unsigned NrVInsn = 8;

    typedef logic [$clog2(NrVInsn)-1:0] vid_t;

    typedef enum logic [2:0] {
        VFU_Alu, VFU_MFpu, VFU_SlideUnit, VFU_MaskUnit, VFU_LoadUnit, VFU_StoreUnit, VFU_None
    } vfu_e;

    typedef struct packed {
        vid_t               id;
        vfu_e               vfu;
        logic [7:0]         op;
        logic [15:0]        vl;
        logic [NrVInsn-1:0] hazard_vs1;
        logic [NrVInsn-1:0] hazard_vs2;
        logic [NrVInsn-1:0] hazard_vm;
        logic [NrVInsn-1:0] hazard_vd;
        logic [NrVInsn-1:0] vinsn_running;
    } pe_req_t;

    typedef struct packed {
        logic [NrVInsn-1:0] vinsn_done;
        logic               exception;
    } pe_resp_t;
endpackage

module pe_vinsn_queue
    import pe_vinsn_pkg::*;
#(
    parameter vfu_e        Vfu        = VFU_Alu,
    parameter int unsigned QueueDepth = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  pe_req_t  pe_req_i,
    input  logic     pe_req_valid_i,
    output logic     pe_req_ready_o,
    output pe_resp_t pe_resp_o,
    output pe_req_t  exe_req_o,
    output logic     exe_valid_o,
    input  logic     exe_ready_i,
    input  logic     exe_done_i,
    input  vid_t     exe_done_id_i
);

    localparam int unsigned PtrW = $clog2(QueueDepth);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [PtrW-1:0] ptr_t;

    pe_req_t            mem_q [QueueDepth];
    pe_req_t            mem_d [QueueDepth];
    ptr_t               rd_ptr_q, rd_ptr_d;
    ptr_t               wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [NrVInsn-1:0] owned_q, owned_d;
    logic [NrVInsn-1:0] done_q, done_d;

    logic    full, empty, match, is_owned, push, pop, done_legal;
    pe_req_t head;

    assign full     = (cnt_q == CntW'(QueueDepth));
    assign empty    = (cnt_q == '0);
    assign match    = (pe_req_i.vfu == Vfu);
    assign is_owned = owned_q[pe_req_i.id];

    // Already-owned requests are repeats held by the sequencer: never stall them.
    assign push           = pe_req_valid_i && match && !is_owned && !full;
    assign pe_req_ready_o = !full || !match || is_owned;

    // Storage is pruned at every edge, so the head is presented as stored.
    assign head        = mem_q[rd_ptr_q];
    assign exe_req_o   = head;
    assign exe_valid_o = !empty && (head.hazard_vd == '0);
    assign pop         = exe_valid_o && exe_ready_i;

    assign done_legal = exe_done_i && owned_q[exe_done_id_i];

    always_comb begin
        for (int i = 0; i < QueueDepth; i++) begin
            mem_d[i]            = mem_q[i];
            mem_d[i].hazard_vs1 = mem_q[i].hazard_vs1 & pe_req_i.vinsn_running;
            mem_d[i].hazard_vs2 = mem_q[i].hazard_vs2 & pe_req_i.vinsn_running;
            mem_d[i].hazard_vm  = mem_q[i].hazard_vm  & pe_req_i.vinsn_running;
            mem_d[i].hazard_vd  = mem_q[i].hazard_vd  & pe_req_i.vinsn_running;
        end
        if (push) begin
            mem_d[wr_ptr_q]            = pe_req_i;
            mem_d[wr_ptr_q].hazard_vs1 = pe_req_i.hazard_vs1 & pe_req_i.vinsn_running;
            mem_d[wr_ptr_q].hazard_vs2 = pe_req_i.hazard_vs2 & pe_req_i.vinsn_running;
            mem_d[wr_ptr_q].hazard_vm  = pe_req_i.hazard_vm  & pe_req_i.vinsn_running;
            mem_d[wr_ptr_q].hazard_vd  = pe_req_i.hazard_vd  & pe_req_i.vinsn_running;
        end
    end

    always_comb begin
        owned_d = owned_q;
        done_d  = '0;
        // Done and accept never target the same ID, so the order here is free.
        if (done_legal) begin
            owned_d[exe_done_id_i] = 1'b0;
            done_d[exe_done_id_i]  = 1'b1;
        end
        if (push) begin
            owned_d[pe_req_i.id] = 1'b1;
        end
        wr_ptr_d = wr_ptr_q + ptr_t'(push);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop);
        cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
    end

    always_comb begin
        pe_resp_o            = '0;
        pe_resp_o.vinsn_done = done_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < QueueDepth; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            owned_q  <= '0;
            done_q   <= '0;
        end else begin
            for (int i = 0; i < QueueDepth; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            owned_q  <= owned_d;
            done_q   <= done_d;
        end
    end

    // A completion for an instruction this PE does not own is a backend bug.
    illegal_done_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        exe_done_i |-> owned_q[exe_done_id_i])
        else $error("exe_done_i for unowned id %0d", exe_done_id_i);

endmodule

// File: tb/tb_pe_vinsn_queue.sv
// Bench for pe_vinsn_queue: directed table, reset sequence, then random traffic,
// all checked against a queue-based reference model.
module tb_pe_vinsn_queue;
    import pe_vinsn_pkg::*;

    localparam int unsigned D = 4;
    localparam vfu_e A = VFU_Alu;
    localparam vfu_e L = VFU_LoadUnit;
    localparam vfu_e N = VFU_None;

    logic     clk_i = 1'b0;
    logic     rst_ni = 1'b0;
    pe_req_t  pe_req_i;
    logic     pe_req_valid_i;
    logic     pe_req_ready_o;
    pe_resp_t pe_resp_o;
    pe_req_t  exe_req_o;
    logic     exe_valid_o;
    logic     exe_ready_i;
    logic     exe_done_i;
    vid_t     exe_done_id_i;

    always #5 clk_i = ~clk_i;

    pe_vinsn_queue #(.Vfu(VFU_Alu), .QueueDepth(D)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .pe_req_i       (pe_req_i),
        .pe_req_valid_i (pe_req_valid_i),
        .pe_req_ready_o (pe_req_ready_o),
        .pe_resp_o      (pe_resp_o),
        .exe_req_o      (exe_req_o),
        .exe_valid_o    (exe_valid_o),
        .exe_ready_i    (exe_ready_i),
        .exe_done_i     (exe_done_i),
        .exe_done_id_i  (exe_done_id_i)
    );

    typedef struct {
        bit vld; vfu_e vfu; vid_t id; logic [15:0] vl;
        logic [7:0] vs1, vs2, vm, vd, run;
        bit rdy, dn; vid_t did;
        bit chk, ey, ev; vid_t eh; logic [7:0] ed;
    } vec_t;

    typedef struct { vid_t id; logic [15:0] vl; logic [7:0] vs1, vs2, vm, vd; } ment_t;

    // Reference model: in-order queue, ownership set, executing list, pending pulse.
    ment_t      mq[$];
    bit         owned[8];
    vid_t       issued[$];
    logic [7:0] m_done;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(bit vld, vfu_e vfu, int id, logic [7:0] hvd, logic [7:0] run,
                                bit rdy, bit dn, int did, bit ey, bit ev, int eh,
                                logic [7:0] ed);
        vec_t v;
        v.vld = vld; v.vfu = vfu; v.id = vid_t'(id); v.vl = 16'(id * 3 + 1);
        v.vs1 = 8'h0; v.vs2 = 8'h0; v.vm = 8'h0; v.vd = hvd; v.run = run;
        v.rdy = rdy; v.dn = dn; v.did = vid_t'(did);
        v.chk = 1'b1; v.ey = ey; v.ev = ev; v.eh = vid_t'(eh); v.ed = ed;
        return v;
    endfunction

    function automatic void model_reset();
        mq.delete();
        issued.delete();
        for (int i = 0; i < 8; i++) owned[i] = 1'b0;
        m_done = '0;
    endfunction

    task automatic step(input vec_t v);
        bit exp_ready, exp_valid, full, acc, pop, legal;
        ment_t e;
        pe_req_i               = '0;
        pe_req_i.id            = v.id;
        pe_req_i.vfu           = v.vfu;
        pe_req_i.vl            = v.vl;
        pe_req_i.hazard_vs1    = v.vs1;
        pe_req_i.hazard_vs2    = v.vs2;
        pe_req_i.hazard_vm     = v.vm;
        pe_req_i.hazard_vd     = v.vd;
        pe_req_i.vinsn_running = v.run;
        pe_req_valid_i         = v.vld;
        exe_ready_i            = v.rdy;
        exe_done_i             = v.dn;
        exe_done_id_i          = v.did;
        #1;
        full      = (mq.size() == D);
        exp_ready = !full || (v.vfu != VFU_Alu) || owned[v.id];
        exp_valid = 1'b0;
        if (mq.size() != 0) exp_valid = (mq[0].vd == 8'h0);
        check("ready", 32'(pe_req_ready_o), 32'(exp_ready));
        check("valid", 32'(exe_valid_o), 32'(exp_valid));
        check("resp", 32'(pe_resp_o), 32'({m_done, 1'b0}));
        if (exp_valid) begin
            check("head_id", 32'(exe_req_o.id), 32'(mq[0].id));
            check("head_vl", 32'(exe_req_o.vl), 32'(mq[0].vl));
            check("head_vs1", 32'(exe_req_o.hazard_vs1), 32'(mq[0].vs1));
            check("head_vs2", 32'(exe_req_o.hazard_vs2), 32'(mq[0].vs2));
            check("head_vm", 32'(exe_req_o.hazard_vm), 32'(mq[0].vm));
            check("head_vd", 32'(exe_req_o.hazard_vd), 32'(mq[0].vd));
        end
        if (v.chk) begin
            check("tbl_ready", 32'(pe_req_ready_o), 32'(v.ey));
            check("tbl_valid", 32'(exe_valid_o), 32'(v.ev));
            check("tbl_done", 32'(pe_resp_o.vinsn_done), 32'(v.ed));
            if (v.ev) check("tbl_head", 32'(exe_req_o.id), 32'(v.eh));
        end
        @(posedge clk_i);
        acc   = v.vld && (v.vfu == VFU_Alu) && !owned[v.id] && !full;
        pop   = exp_valid && v.rdy;
        legal = v.dn && owned[v.did];
        m_done = legal ? (8'h1 << v.did) : 8'h0;
        if (legal) begin
            owned[v.did] = 1'b0;
            for (int i = 0; i < issued.size(); i++) begin
                if (issued[i] == v.did) begin
                    issued.delete(i);
                    break;
                end
            end
        end
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            e.vs1 &= v.run; e.vs2 &= v.run; e.vm &= v.run; e.vd &= v.run;
            mq[i] = e;
        end
        if (pop) begin
            issued.push_back(mq[0].id);
            void'(mq.pop_front());
        end
        if (acc) begin
            e.id = v.id; e.vl = v.vl;
            e.vs1 = v.vs1 & v.run; e.vs2 = v.vs2 & v.run;
            e.vm = v.vm & v.run; e.vd = v.vd & v.run;
            mq.push_back(e);
            owned[v.id] = 1'b1;
        end
        @(negedge clk_i);
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        model_reset();
        pe_req_i = '0; pe_req_valid_i = 0; exe_ready_i = 0; exe_done_i = 0; exe_done_id_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_ready", 32'(pe_req_ready_o), 32'd1);
        check("rst_valid", 32'(exe_valid_o), 32'd0);
        check("rst_req", 32'(exe_req_o != '0), 32'd0);
        check("rst_resp", 32'(pe_resp_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        //           vld vfu id hvd run rdy dn did  ey ev eh ed
        // Basic flow
        tbl.push_back(mk(0, N, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, A, 3, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 1, 3, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 1, 3, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h08));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        // Filtering, then one request held for five cycles
        tbl.push_back(mk(1, L, 1, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, A, 2, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, A, 2, 0, 0, 0, 0, 0, 1, 1, 2, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 1, 2, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 1, 2, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h04));
        // Full queue
        tbl.push_back(mk(1, A, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, A, 1, 0, 0, 0, 0, 0, 1, 1, 0, 8'h00));
        tbl.push_back(mk(1, A, 2, 0, 0, 0, 0, 0, 1, 1, 0, 8'h00));
        tbl.push_back(mk(1, A, 3, 0, 0, 0, 0, 0, 1, 1, 0, 8'h00));
        tbl.push_back(mk(1, A, 4, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, A, 3, 0, 0, 0, 0, 0, 1, 1, 0, 8'h00));
        tbl.push_back(mk(1, A, 4, 0, 0, 1, 0, 0, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, A, 4, 0, 0, 0, 0, 0, 1, 1, 1, 8'h00));
        for (int i = 1; i <= 4; i++) tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 1, i, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 1, 0, 1, 0, 0, 8'h00));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(0, N, 0, 0, 0, 1, 1, i, 1, 0, 0, 8'h1 << (i - 1)));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h10));
        // WAW gating
        tbl.push_back(mk(1, A, 1, 1, 1, 1, 0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 1, 1, 0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 1, 1, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 1, 1, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h02));
        // Push, pop and done in one cycle
        tbl.push_back(mk(1, A, 2, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(1, A, 6, 0, 0, 1, 0, 0, 1, 1, 2, 8'h00));
        tbl.push_back(mk(1, A, 5, 0, 0, 1, 1, 2, 1, 1, 6, 8'h00));
        tbl.push_back(mk(1, A, 5, 0, 0, 1, 0, 0, 1, 1, 5, 8'h04));
        tbl.push_back(mk(1, A, 5, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 1, 6, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 1, 5, 1, 0, 0, 8'h40));
        tbl.push_back(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h20));
        foreach (tbl[i]) step(tbl[i]);

        // Reset with three queued instructions and one executing
        step(mk(1, A, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00));
        step(mk(1, A, 1, 0, 0, 1, 0, 0, 1, 1, 0, 8'h00));
        step(mk(1, A, 2, 0, 0, 0, 0, 0, 1, 1, 1, 8'h00));
        step(mk(1, A, 3, 0, 0, 0, 0, 0, 1, 1, 1, 8'h00));
        pe_req_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_ready", 32'(pe_req_ready_o), 32'd1);
        check("mid_rst_valid", 32'(exe_valid_o), 32'd0);
        check("mid_rst_req", 32'(exe_req_o != '0), 32'd0);
        check("mid_rst_resp", 32'(pe_resp_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) step(mk(0, N, 0, 0, 0, 1, 0, 0, 1, 0, 0, 8'h00));

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            v = mk(0, N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
            v.chk = 1'b0;
            v.vld = ($urandom % 4) != 0;
            v.vfu = (($urandom % 4) != 0) ? VFU_Alu : vfu_e'(3'($urandom_range(1, 6)));
            v.id  = vid_t'($urandom % 8);
            v.vl  = 16'($urandom);
            v.vs1 = 8'($urandom);
            v.vs2 = 8'($urandom);
            v.vm  = 8'($urandom);
            v.vd  = (($urandom % 3) == 0) ? 8'($urandom) : 8'h00;
            v.run = (($urandom % 4) == 0) ? 8'hff : 8'($urandom);
            v.rdy = ($urandom % 4) != 0;
            if (issued.size() != 0 && ($urandom % 2) == 1) begin
                v.dn  = 1'b1;
                v.did = issued[$urandom % issued.size()];
            end
            step(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
